// File: rtl/rgb_pl9823_rx.sv
// PL9823 single-wire NRZ receiver: measures high pulses on a synchronized DIN,
// assembles 24-bit RGB pixels and flags frame end on a long low reset gap.
module rgb_pl9823_rx #(
  parameter int unsigned THRESH_CYC   = 43,
  parameter int unsigned MIN_HIGH_CYC = 5,
  parameter int unsigned MAX_HIGH_CYC = 120,
  parameter int unsigned RESET_CYC    = 2500,
  parameter int unsigned CW           = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN,
  output logic [7:0] OUT_ROT,
  output logic [7:0] OUT_GRUEN,
  output logic [7:0] OUT_BLAU,
  output logic       PIX_VALID,
  output logic [7:0] PIX_INDEX,
  output logic       FRAME_DONE,
  output logic [7:0] PIX_COUNT,
  output logic       ERR
);

  localparam logic [CW-1:0] THRESH_C = CW'(THRESH_CYC);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_HIGH_CYC);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_HIGH_CYC);
  localparam logic [CW-1:0] RESET_C  = CW'(RESET_CYC);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH} state_t;

  state_t        state;
  logic          s1, s2, ds;
  logic [CW-1:0] cnt;
  logic [22:0]   sr;
  logic [4:0]    bit_cnt;
  logic [7:0]    pix_cnt;

  logic          rise, fall, din_edge;
  logic [23:0]   sr_next;

  // Edges are seen one cycle ahead of ds, so cnt holds the full length of the ending level.
  assign rise     = s2 & ~ds;
  assign fall     = ~s2 & ds;
  assign din_edge = s2 ^ ds;
  assign sr_next  = {sr, (cnt >= THRESH_C)};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= SYNC;
      s1         <= 1'b0;
      s2         <= 1'b0;
      ds         <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      OUT_ROT    <= '0;
      OUT_GRUEN  <= '0;
      OUT_BLAU   <= '0;
      PIX_VALID  <= 1'b0;
      PIX_INDEX  <= '0;
      FRAME_DONE <= 1'b0;
      PIX_COUNT  <= '0;
      ERR        <= 1'b0;
    end else begin
      s1 <= DIN;
      s2 <= s1;
      ds <= s2;

      if (din_edge)      cnt <= CW'(1);
      else if (cnt != '1) cnt <= cnt + 1'b1;

      PIX_VALID  <= 1'b0;
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;

      case (state)
        SYNC: begin
          if (!ds && cnt >= RESET_C) state <= IDLE;
        end

        IDLE: begin
          if (!ds && cnt == RESET_C) begin
            if (bit_cnt != '0) ERR <= 1'b1;
            if (pix_cnt != '0) begin
              FRAME_DONE <= 1'b1;
              PIX_COUNT  <= pix_cnt;
            end
            bit_cnt <= '0;
            pix_cnt <= '0;
          end
          if (rise) state <= HIGH;
        end

        HIGH: begin
          if (cnt == MAX_C) begin
            ERR     <= 1'b1;
            bit_cnt <= '0;
            pix_cnt <= '0;
            state   <= SYNC;
          end else if (fall) begin
            state <= IDLE;
            if (cnt >= MIN_C) begin
              sr <= sr_next[22:0];
              if (bit_cnt == 5'd23) begin
                OUT_ROT   <= sr_next[23:16];
                OUT_GRUEN <= sr_next[15:8];
                OUT_BLAU  <= sr_next[7:0];
                PIX_INDEX <= pix_cnt;
                PIX_VALID <= 1'b1;
                bit_cnt   <= '0;
                if (pix_cnt != 8'hFF) pix_cnt <= pix_cnt + 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule
